dmem_mmio: RTL and testbench

Data-side responder for the single-cycle MIPS core. It answers the core's data port: the core drives `addr`, `wdata` and `we`, and this block returns `rdata`. Behind that port it holds a word-addressed data RAM plus a small memory-mapped I/O window with an LED register, a synchronized switch input and a compare timer that can raise an interrupt. Because the core is single-cycle, reads are combinational and writes commit on the clock edge.

---
 rtl/dmem_mmio.sv | 149 ++++++++++++++
 tb/tb_dmem_mmio.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus an MMIO window
// holding an LED register, synchronized switches and a compare timer with interrupt.
module dmem_mmio #(
    parameter int unsigned DM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        irq
);

    localparam int unsigned IdxW = $clog2(DM_WORDS);

    localparam logic [7:0] OffLed   = 8'h00;
    localparam logic [7:0] OffSw    = 8'h04;
    localparam logic [7:0] OffTcnt  = 8'h08;
    localparam logic [7:0] OffTcmp  = 8'h0C;
    localparam logic [7:0] OffTctrl = 8'h10;
    localparam logic [7:0] OffTstat = 8'h14;

    typedef enum logic {StIdle, StRun} tstate_e;

    logic [31:0] mem [DM_WORDS];

    logic [IdxW-1:0] idx;
    logic [7:0]      off;
    logic            is_ram, is_mmio;
    logic            wr_led, wr_tcnt, wr_tcmp, wr_tctrl, wr_tstat;

    logic [15:0] led_q, led_d;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [31:0] tcnt_q, tcnt_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        match_q, match_d;
    tstate_e     state_q, state_d;
    logic        hit;

    // Address bits outside the decoded fields only exist to alias.
    logic unused_addr;
    assign unused_addr = ^{addr[15:8], addr[1:0]};

    assign idx     = addr[IdxW+1:2];
    assign off     = {addr[7:2], 2'b00};
    assign is_ram  = (addr[31:16] == 16'h0000);
    assign is_mmio = (addr[31:16] == 16'hFFFF);

    assign wr_led   = we && is_mmio && (off == OffLed);
    assign wr_tcnt  = we && is_mmio && (off == OffTcnt);
    assign wr_tcmp  = we && is_mmio && (off == OffTcmp);
    assign wr_tctrl = we && is_mmio && (off == OffTctrl);
    assign wr_tstat = we && is_mmio && (off == OffTstat);

    // RAM has no reset; stores still land while rst is high.
    always_ff @(posedge clk) begin
        if (we && is_ram) begin
            mem[idx] <= wdata;
        end
    end

    assign hit = (state_q == StRun) && (tcnt_q == tcmp_q);

    always_comb begin
        led_d   = led_q;
        tcnt_d  = tcnt_q;
        tcmp_d  = tcmp_q;
        auto_d  = auto_q;
        ie_d    = ie_q;
        match_d = match_q;
        state_d = state_q;

        unique case (state_q)
            StIdle: ;
            StRun: begin
                if (!hit) begin
                    tcnt_d = tcnt_q + 32'd1;
                end else if (auto_q) begin
                    tcnt_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Core writes win over timer updates; a hardware match wins over W1C.
        if (wr_led)   led_d  = wdata[15:0];
        if (wr_tcnt)  tcnt_d = wdata;
        if (wr_tcmp)  tcmp_d = wdata;
        if (wr_tctrl) begin
            state_d = wdata[0] ? StRun : StIdle;
            auto_d  = wdata[1];
            ie_d    = wdata[2];
        end
        if (wr_tstat && wdata[0]) match_d = 1'b0;
        if (hit)                  match_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            tcnt_q    <= '0;
            tcmp_q    <= 32'hFFFF_FFFF;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            match_q   <= 1'b0;
            state_q   <= StIdle;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            tcnt_q    <= tcnt_d;
            tcmp_q    <= tcmp_d;
            auto_q    <= auto_d;
            ie_q      <= ie_d;
            match_q   <= match_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = mem[idx];
        end else if (is_mmio) begin
            case (off)
                OffLed:   rdata = {16'b0, led_q};
                OffSw:    rdata = {16'b0, sw_sync_q};
                OffTcnt:  rdata = tcnt_q;
                OffTcmp:  rdata = tcmp_q;
                OffTctrl: rdata = {29'b0, ie_q, auto_q, state_q == StRun};
                OffTstat: rdata = {31'b0, match_q};
                default:  rdata = '0;
            endcase
        end
    end

    assign led = led_q;
    assign irq = match_q & ie_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: one vector per clock, driven at negedge and checked
// just after, before the rising edge that commits it.
module tb_dmem_mmio;

    localparam logic [31:0] ALed   = 32'hFFFF_0000;
    localparam logic [31:0] ASw    = 32'hFFFF_0004;
    localparam logic [31:0] ATcnt  = 32'hFFFF_0008;
    localparam logic [31:0] ATcmp  = 32'hFFFF_000C;
    localparam logic [31:0] ATctrl = 32'hFFFF_0010;
    localparam logic [31:0] ATstat = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [15:0] sw;
    logic [15:0] led;
    logic        irq;

    dmem_mmio #(.DM_WORDS(256)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .sw    (sw),
        .led   (led),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        logic        chk;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_no  = 0;

    logic        rst_now = 1'b0;
    logic [15:0] sw_now  = 16'h0000;
    logic [15:0] led_now = 16'h0000;

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic c, input logic [31:0] e, input logic i);
        vec_t t;
        t.rst       = rst_now;
        t.we        = w;
        t.addr      = a;
        t.wdata     = d;
        t.sw        = sw_now;
        t.chk       = c;
        t.exp_rdata = e;
        t.exp_led   = led_now;
        t.exp_irq   = i;
        return t;
    endfunction

    function automatic vec_t rd(input logic [31:0] a, input logic [31:0] e,
                                input logic i = 1'b0);
        return mk(1'b0, a, 32'h0, 1'b1, e, i);
    endfunction

    // Write whose same-cycle read must return the old value.
    function automatic vec_t wr(input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] old, input logic i = 1'b0);
        return mk(1'b1, a, d, 1'b1, old, i);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL vec %0d %s: got %h, expected %h", vec_no, nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        @(negedge clk);
        rst   = t.rst;
        we    = t.we;
        addr  = t.addr;
        wdata = t.wdata;
        sw    = t.sw;
        #1;
        if (t.chk) check("rdata", rdata, t.exp_rdata);
        check("led", {16'b0, led}, {16'b0, t.exp_led});
        check("irq", {31'b0, irq}, {31'b0, t.exp_irq});
        vec_no++;
    endtask

    initial begin
        rst   = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        sw    = '0;
        repeat (2) @(posedge clk);

        // Reset values
        tbl.push_back(rd(ALed, 32'h0));
        tbl.push_back(rd(ATcnt, 32'h0));
        tbl.push_back(rd(ATcmp, 32'hFFFF_FFFF));
        tbl.push_back(rd(ATctrl, 32'h0));
        tbl.push_back(rd(ATstat, 32'h0));
        // RAM store/load, aliasing, read-during-write
        tbl.push_back(mk(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0));
        tbl.push_back(rd(32'h0000_0010, 32'h1234_5678));
        tbl.push_back(rd(32'h0000_0014, 32'hDEAD_BEEF));
        tbl.push_back(rd(32'h0000_0410, 32'h1234_5678));
        tbl.push_back(wr(32'h0000_0010, 32'h0BAD_F00D, 32'h1234_5678));
        tbl.push_back(rd(32'h0000_0013, 32'h0BAD_F00D));
        // LED and switch synchronizer
        tbl.push_back(wr(ALed, 32'hABCD_5A5A, 32'h0));
        led_now = 16'h5A5A;
        tbl.push_back(rd(ALed, 32'h0000_5A5A));
        sw_now = 16'h00F0;
        tbl.push_back(rd(ASw, 32'h0));
        tbl.push_back(rd(ASw, 32'h0));
        tbl.push_back(rd(ASw, 32'h0000_00F0));
        // Unmapped accesses
        tbl.push_back(wr(32'h8000_0000, 32'hFFFF_FFFF, 32'h0));
        tbl.push_back(wr(32'hFFFF_0020, 32'hFFFF_FFFF, 32'h0));
        tbl.push_back(rd(32'h8000_0000, 32'h0));
        tbl.push_back(rd(32'hFFFF_0020, 32'h0));
        tbl.push_back(rd(ALed, 32'h0000_5A5A));
        // One-shot: match 6 edges after the TCTRL write
        tbl.push_back(wr(ATcnt, 32'h0, 32'h0));
        tbl.push_back(wr(ATcmp, 32'h5, 32'hFFFF_FFFF));
        tbl.push_back(wr(ATctrl, 32'h5, 32'h0));
        for (int i = 0; i <= 5; i++) tbl.push_back(rd(ATcnt, i));
        tbl.push_back(rd(ATstat, 32'h1, 1'b1));
        tbl.push_back(rd(ATcnt, 32'h5, 1'b1));
        tbl.push_back(rd(ATctrl, 32'h4, 1'b1));
        tbl.push_back(wr(ATstat, 32'h1, 32'h1, 1'b1));
        tbl.push_back(rd(ATstat, 32'h0));
        // Auto-reload 0,1,2,0,...; clear colliding with a match leaves MATCH set
        tbl.push_back(wr(ATcnt, 32'h0, 32'h5));
        tbl.push_back(wr(ATcmp, 32'h2, 32'h5));
        tbl.push_back(wr(ATctrl, 32'h3, 32'h4));
        tbl.push_back(rd(ATcnt, 32'h0));
        tbl.push_back(rd(ATcnt, 32'h1));
        tbl.push_back(rd(ATcnt, 32'h2));
        tbl.push_back(rd(ATcnt, 32'h0));
        tbl.push_back(rd(ATstat, 32'h1));
        tbl.push_back(wr(ATstat, 32'h1, 32'h1));
        tbl.push_back(rd(ATstat, 32'h1));
        tbl.push_back(wr(ATstat, 32'h1, 32'h1));
        tbl.push_back(rd(ATstat, 32'h0));
        tbl.push_back(rd(ATcnt, 32'h0));
        // TCNT write overrides increment, then 32-bit wrap
        tbl.push_back(wr(ATcmp, 32'h10, 32'h2));
        tbl.push_back(wr(ATcnt, 32'hFFFF_FFFE, 32'h2));
        tbl.push_back(rd(ATcnt, 32'hFFFF_FFFE));
        tbl.push_back(rd(ATcnt, 32'hFFFF_FFFF));
        tbl.push_back(rd(ATcnt, 32'h0));
        tbl.push_back(wr(ATstat, 32'h1, 32'h1));
        tbl.push_back(rd(ATstat, 32'h0));

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

        // No match until TCNT reaches 0x10
        for (int i = 3; i <= 15; i++) apply(rd(ATstat, 32'h0));
        apply(rd(ATcnt, 32'h10));
        apply(rd(ATstat, 32'h1));
        apply(wr(ATctrl, 32'h7, 32'h3));
        apply(rd(ATctrl, 32'h7, 1'b1));

        // One-cycle reset mid-count, with a RAM store in the same cycle
        rst_now = 1'b1;
        apply(mk(1'b1, 32'h0000_0020, 32'h55AA_55AA, 1'b0, 32'h0, 1'b1));
        rst_now = 1'b0;
        led_now = 16'h0000;
        apply(rd(ASw, 32'h0));
        apply(rd(ALed, 32'h0));
        apply(rd(ATcnt, 32'h0));
        apply(rd(ATcnt, 32'h0));
        apply(rd(ATcmp, 32'hFFFF_FFFF));
        apply(rd(ATctrl, 32'h0));
        apply(rd(ATstat, 32'h0));
        apply(rd(32'h0000_0010, 32'h0BAD_F00D));
        apply(rd(32'h0000_0014, 32'hDEAD_BEEF));
        apply(rd(32'h0000_0020, 32'h55AA_55AA));
        apply(rd(ASw, 32'h0000_00F0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
